// File: rtl/logic_unit_pkg.sv
// Shared opcode and state definitions for the logic-unit scheduler and its gate bank.
package logic_unit_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/logic_gate_bank.sv
// Combinational gate bank: one quad package of each gate type per 4-bit slice,
// followed by a 4:1 opcode-selected mux.
module logic_gate_bank
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // Operands are padded up to whole quad packages; extra bits are dropped at the output.
  localparam int NPKG = (WIDTH + 3) / 4;
  localparam int PADW = NPKG * 4;

  logic [PADW-1:0] a_pad;
  logic [PADW-1:0] b_pad;
  logic [PADW-1:0] and_y;
  logic [PADW-1:0] or_y;
  logic [PADW-1:0] xor_y;
  logic [PADW-1:0] nand_y;
  logic [PADW-1:0] mux_y;

  assign a_pad = PADW'(a);
  assign b_pad = PADW'(b);

  generate
    for (genvar gi = 0; gi < NPKG; gi++) begin : g_pkg
      ls7408 u_and  (.a(a_pad[gi*4 +: 4]), .b(b_pad[gi*4 +: 4]), .y(and_y[gi*4 +: 4]));
      ls7432 u_or   (.a(a_pad[gi*4 +: 4]), .b(b_pad[gi*4 +: 4]), .y(or_y[gi*4 +: 4]));
      ls7486 u_xor  (.a(a_pad[gi*4 +: 4]), .b(b_pad[gi*4 +: 4]), .y(xor_y[gi*4 +: 4]));
      ls7400 u_nand (.a(a_pad[gi*4 +: 4]), .b(b_pad[gi*4 +: 4]), .y(nand_y[gi*4 +: 4]));
    end
  endgenerate

  always_comb begin
    mux_y = and_y;
    case (op)
      OP_AND:  mux_y = and_y;
      OP_OR:   mux_y = or_y;
      OP_XOR:  mux_y = xor_y;
      OP_NAND: mux_y = nand_y;
      default: mux_y = and_y;
    endcase
  end

  assign y = mux_y[WIDTH-1:0];

endmodule

// File: rtl/ls7400.sv
// Quad 2-input NAND gate package model.
module ls7400 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = ~(a & b);
endmodule

// File: rtl/ls7408.sv
// Quad 2-input AND gate package model.
module ls7408 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a & b;
endmodule

// File: rtl/ls7432.sv
// Quad 2-input OR gate package model.
module ls7432 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a | b;
endmodule

// File: rtl/ls7486.sv
// Quad 2-input XOR gate package model.
module ls7486 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic_unit_sched.sv
// Round-robin scheduler sharing one gate bank among NREQ requesters.
// Each transaction takes three cycles: IDLE (arbitrate), EXEC (evaluate), RESP (done).
module logic_unit_sched
  import logic_unit_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [WIDTH-1:0]      result
);

  // Returns {found, index} of the first set request scanning upward from ptr.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (r[idx]) res = {1'b1, IDW'(idx)};
    end
    return res;
  endfunction

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   cur_id_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             done_reg;
  logic [IDW-1:0]   done_id_reg;
  logic [WIDTH-1:0] result_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  logic [IDW:0]     pick;
  logic             win_valid;
  logic [IDW-1:0]   win_idx;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [WIDTH-1:0] bank_y;

  always_comb begin
    pick      = rr_pick(req, rr_ptr_reg);
    win_valid = pick[IDW];
    win_idx   = pick[IDW-1:0];
    win_op    = op[2*win_idx +: 2];
    win_a     = a[win_idx*WIDTH +: WIDTH];
    win_b     = b[win_idx*WIDTH +: WIDTH];
  end

  logic_gate_bank #(.WIDTH(WIDTH)) u_bank (
    .op (op_reg),
    .a  (a_reg),
    .b  (b_reg),
    .y  (bank_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      rr_ptr_reg  <= '0;
      cur_id_reg  <= '0;
      gnt_reg     <= '0;
      done_reg    <= 1'b0;
      done_id_reg <= '0;
      result_reg  <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (win_valid) begin
            gnt_reg    <= NREQ'(1) << win_idx;
            cur_id_reg <= win_idx;
            op_reg     <= win_op;
            a_reg      <= win_a;
            b_reg      <= win_b;
            state_reg  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_reg  <= bank_y;
          done_id_reg <= cur_id_reg;
          done_reg    <= 1'b1;
          state_reg   <= ST_RESP;
        end
        ST_RESP: begin
          // The served requester becomes lowest priority for the next pick.
          gnt_reg    <= '0;
          done_reg   <= 1'b0;
          rr_ptr_reg <= IDW'((int'(cur_id_reg) + 1) % NREQ);
          state_reg  <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = done_reg;
  assign done_id = done_id_reg;
  assign result  = result_reg;

endmodule

// File: tb/tb_logic_unit_sched.sv
// Self-checking bench for logic_unit_sched: directed vectors, corner sequences,
// and randomized transactions against a transaction-level reference model.
module tb_logic_unit_sched;

  localparam int NREQ = 4;
  localparam int W    = 4;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] a;
  logic [W*NREQ-1:0] b;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic [1:0]      done_id;
  logic [W-1:0]    result;

  int vectors;
  int miscompares;

  logic_unit_sched #(.NREQ(NREQ), .WIDTH(W), .IDW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .a       (a),
    .b       (b),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [7:0]  o;
    logic [15:0] aa;
    logic [15:0] bb;
    int          eid;
    logic [3:0]  eres;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_op(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Starts in an IDLE cycle at a falling edge; ends at the falling edge of the next IDLE cycle.
  // chg: 0 leave inputs alone, 1 force the winner's a to 4'hF, 2 scramble all operands in EXEC.
  task automatic txn(input string nm, input logic [3:0] rq, input logic [7:0] o,
                     input logic [15:0] aa, input logic [15:0] bb, input int eid,
                     input logic [3:0] eres, input bit drop, input int chg);
    logic [3:0] oh;
    oh = 4'(1 << eid);
    req = rq; op = o; a = aa; b = bb;
    @(negedge clk);
    chk({nm, "_gnt_exec"}, 32'(gnt), 32'(oh));
    chk({nm, "_busy_exec"}, 32'(busy), 32'd1);
    chk({nm, "_done_exec"}, 32'(done), 32'd0);
    if (chg == 1) a[eid*W +: W] = 4'hF;
    else if (chg == 2) begin
      a = 16'($urandom); b = 16'($urandom); op = 8'($urandom);
    end
    @(negedge clk);
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_done_id"}, 32'(done_id), 32'(eid));
    chk({nm, "_result"}, 32'(result), 32'(eres));
    chk({nm, "_gnt_resp"}, 32'(gnt), 32'(oh));
    if (drop) req[eid] = 1'b0;
    @(negedge clk);
    chk({nm, "_done_idle"}, 32'(done), 32'd0);
    chk({nm, "_gnt_idle"}, 32'(gnt), 32'd0);
    chk({nm, "_busy_idle"}, 32'(busy), 32'd0);
    chk({nm, "_result_held"}, 32'(result), 32'(eres));
    $display("txn %s id=%0d result=%h", nm, done_id, result);
  endtask

  initial begin
    logic [3:0]  pend;
    logic [3:0]  rbits;
    logic [7:0]  ro;
    logic [15:0] ra;
    logic [15:0] rb;
    int          ptr;
    int          win;
    logic [3:0]  exp_r;

    vectors = 0;
    miscompares = 0;

    vt[0] = '{4'b0001, 8'h00, 16'h000A, 16'h000C, 0, 4'b1000};
    vt[1] = '{4'b0100, 8'h10, 16'h0F00, 16'h0500, 2, 4'b1111};
    vt[2] = '{4'b0100, 8'h20, 16'h0F00, 16'h0500, 2, 4'b1010};
    vt[3] = '{4'b0100, 8'h30, 16'h0F00, 16'h0500, 2, 4'b1010};
    vt[4] = '{4'b0100, 8'h00, 16'h0F00, 16'h0500, 2, 4'b0101};

    rst = 1'b1; req = '0; op = '0; a = '0; b = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_done_id", 32'(done_id), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single AND, then opcode sweep on requester 2 (leaves rr_ptr at 3).
    for (int i = 0; i < 5; i++)
      txn($sformatf("vec%0d", i), vt[i].rq, vt[i].o, vt[i].aa, vt[i].bb, vt[i].eid, vt[i].eres, 1'b1, 0);

    // Wrap and priority: requester 3 before requester 0.
    txn("wrap_first", 4'b1001, 8'h00, 16'hF00F, 16'hF00F, 3, 4'hF, 1'b1, 0);
    txn("wrap_second", 4'b0001, 8'h00, 16'hF00F, 16'hF00F, 0, 4'hF, 1'b1, 0);

    // Reset held two cycles while requester 1 is in EXEC.
    req = 4'b0010; op = 8'h00; a = 16'h00A0; b = 16'h00C0;
    @(negedge clk);
    chk("rst_mid_gnt_before", 32'(gnt), 32'b0010);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    rst = 1'b0; req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(done), 32'd0);
    end

    // Round-robin with all requests held; rr_ptr restarts at 0 after reset.
    for (int i = 0; i < 5; i++)
      txn($sformatf("rr%0d", i), 4'b1111, 8'h00, 16'h3210, 16'hFFFF, i % 4, 4'(i % 4), 1'b0, 0);
    req = '0;

    // Operand stability: a3 changes during EXEC.
    txn("stable", 4'b1000, 8'h80, 16'h3000, 16'h6000, 3, 4'b0101, 1'b1, 1);

    // Randomized transactions against the reference model; rr_ptr is now 0.
    ptr = 0;
    pend = '0;
    for (int n = 0; n < 60; n++) begin
      rbits = 4'($urandom);
      pend = pend | rbits;
      if (pend == 0) pend[$urandom_range(3, 0)] = 1'b1;
      ro = 8'($urandom); ra = 16'($urandom); rb = 16'($urandom);
      win = -1;
      for (int k = 0; k < NREQ; k++)
        if (win < 0 && pend[(ptr + k) % NREQ]) win = (ptr + k) % NREQ;
      exp_r = ref_op(ro[2*win +: 2], ra[4*win +: 4], rb[4*win +: 4]);
      txn($sformatf("rand%0d", n), pend, ro, ra, rb, win, exp_r, 1'b1, 2);
      pend[win] = 1'b0;
      ptr = (win + 1) % NREQ;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
